// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: multi-cycle multiply/divide unit with the HI/LO result registers.
// Multiplies complete after MUL_LATENCY cycles. Divides use radix-2 restoring
// iterations on magnitudes, followed by one FIX cycle that applies the signs.
module mips_muldiv_unit #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int CNT_MAX = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;       // raw src_a (multiplicand, or divide-by-zero HI)
    logic [WIDTH-1:0] b_q, b_d;       // raw src_b (multiplier)
    logic             sgn_q, sgn_d;   // signed multiply
    logic [WIDTH-1:0] quo_q, quo_d;   // dividend magnitude shifting into the quotient
    logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder
    logic [WIDTH-1:0] dvs_q, dvs_d;   // divisor magnitude
    logic             negq_q, negq_d; // quotient must be negated in FIX
    logic             negr_q, negr_d; // remainder must be negated in FIX
    logic             dz_q, dz_d;     // divide by zero seen at capture
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   rem_sub;
    logic               a_neg, b_neg, div_sgn;

    // Full-width product from the captured operands; sign extension selects MULT vs MULTU.
    always_comb begin
        a_ext = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod  = a_ext * b_ext;
    end

    // One restoring step: shift in the next dividend bit and subtract the divisor if it fits.
    // The difference is always below the divisor, so WIDTH bits are enough to hold it.
    always_comb begin
        trial   = {rem_q, quo_q[WIDTH-1]};
        rem_sub = trial[WIDTH-1:0] - dvs_q;
    end

    // Operand signs for the divider. They are only used when DIV is accepted.
    always_comb begin
        div_sgn = (op == OP_DIV);
        a_neg   = div_sgn & src_a[WIDTH-1];
        b_neg   = div_sgn & src_b[WIDTH-1];
    end

    // Next-state, datapath, and output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    unique case (op)
                        OP_MULT, OP_MULTU: begin
                            a_d     = src_a;
                            b_d     = src_b;
                            sgn_d   = (op == OP_MULT);
                            cnt_d   = CW'(MUL_LATENCY - 1);
                            state_d = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            a_d     = src_a;
                            dz_d    = (src_b == '0);
                            quo_d   = a_neg ? -src_a : src_a;
                            dvs_d   = b_neg ? -src_b : src_b;
                            rem_d   = '0;
                            negq_d  = a_neg ^ b_neg;
                            negr_d  = a_neg;
                            cnt_d   = CW'(WIDTH - 1);
                            state_d = S_DIV;
                        end
                        OP_MTHI: hi_d = src_a;
                        OP_MTLO: lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (cnt_q == '0) begin
                    {hi_d, lo_d} = prod;
                    done_d       = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DIV: begin
                if (trial >= {1'b0, dvs_q}) begin
                    rem_d = rem_sub;
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == '0) state_d = S_FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_FIX: begin
                // MIN / -1 needs no special case: |MIN| as unsigned equals MIN, and the
                // two negative operands leave the quotient un-negated.
                if (dz_q) begin
                    lo_d = '1;
                    hi_d = a_q;
                end else begin
                    lo_d = negq_q ? -quo_q : quo_q;
                    hi_d = negr_q ? -rem_q : rem_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers. Reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Bench for mips_muldiv_unit (WIDTH=32, MUL_LATENCY=5).
// Each issued mul/div pushes its expected {hi,lo} to a scoreboard queue.
// The entry is popped and compared when the unit signals completion.
module tb_mips_muldiv_unit;

    localparam int W = 32;
    localparam int L = 5;

    logic         clk, rst, start;
    logic [2:0]   op;
    logic [W-1:0] src_a, src_b;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int total = 0;
    int bad   = 0;
    logic [63:0] sb_q[$];

    mips_muldiv_unit #(.WIDTH(W), .MUL_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference {hi,lo} built from the language's own arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int     sq, sr;
        logic [31:0] uq, ur;
        model = '0;
        case (o)
            3'd0: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                model = sa * sb;
            end
            3'd1: model = {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {32'd0, 32'h8000_0000};
                else begin
                    sq = $signed(a) / $signed(b);
                    sr = $signed(a) % $signed(b);
                    model = {sr, sq};
                end
            end
            3'd3: begin
                if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
                else begin
                    uq = a / b;
                    ur = a % b;
                    model = {ur, uq};
                end
            end
            default: model = '0;
        endcase
    endfunction

    // Drive one start strobe through an active edge; optionally record the expected result.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
        start = 1'b1; op = o; src_a = a; src_b = b;
        if (push) sb_q.push_back(model(o, a, b));
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); src_a = $urandom; src_b = $urandom;
    endtask

    // Count the busy cycles until busy falls (bounded), then report the done level at that point.
    task automatic wait_done(output int cyc, output logic dn);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(posedge clk); #1;
        end
        dn = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (hi !== 32'd0)  begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
        total++; if (lo !== 32'd0)  begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mt();
        issue(3'd5, 32'h1234_5678, 32'h0, 1'b0);
        total++; if (lo !== 32'h1234_5678) begin bad++; $display("FAIL mtlo_lo got=%h want=12345678", lo); end
        total++; if (hi !== 32'd0)         begin bad++; $display("FAIL mtlo_hi got=%h want=0", hi); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL mtlo_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0)        begin bad++; $display("FAIL mtlo_done got=%b want=0", done); end
        issue(3'd4, 32'hCAFE_F00D, 32'h0, 1'b0);
        total++; if (hi !== 32'hCAFE_F00D) begin bad++; $display("FAIL mthi_hi got=%h want=cafef00d", hi); end
        total++; if (lo !== 32'h1234_5678) begin bad++; $display("FAIL mthi_lo got=%h want=12345678", lo); end
        total++; if (done !== 1'b0)        begin bad++; $display("FAIL mthi_done got=%b want=0", done); end
        // Reserved op: nothing may change.
        issue(3'd6, 32'h1111_1111, 32'h2, 1'b0);
        total++; if (busy !== 1'b0 || hi !== 32'hCAFE_F00D || lo !== 32'h1234_5678) begin
            bad++; $display("FAIL reserved_op busy=%b hi=%h lo=%h want 0/cafef00d/12345678", busy, hi, lo);
        end
    endtask

    // Issue a mul/div, check its latency and done pulse, then compare against the scoreboard.
    task automatic test_muldiv(input string name, input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input int lat);
        int cyc; logic dn; logic [63:0] exp;
        logic [31:0] hi0, lo0;
        hi0 = hi; lo0 = lo;
        issue(o, a, b, 1'b1);
        total++; if (hi !== hi0 || lo !== lo0) begin
            bad++; $display("FAIL %s_stale hi=%h lo=%h want %h/%h", name, hi, lo, hi0, lo0);
        end
        wait_done(cyc, dn);
        total++; if (cyc !== lat) begin bad++; $display("FAIL %s_busy_cycles got=%0d want=%0d", name, cyc, lat); end
        total++; if (dn !== 1'b1) begin bad++; $display("FAIL %s_done got=%b want=1", name, dn); end
        total++;
        if (sb_q.size() == 0) begin bad++; $display("FAIL %s_scoreboard empty", name); end
        else begin
            exp = sb_q.pop_front();
            if ({hi, lo} !== exp) begin
                bad++; $display("FAIL %s_result got=%h_%h want=%h_%h", name, hi, lo, exp[63:32], exp[31:0]);
            end
        end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL %s_done_pulse got=%b want=0", name, done); end
    endtask

    task automatic test_mul();
        test_muldiv("mult_neg",  3'd0, 32'hFFFF_FFFD, 32'd7, L);
        total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            bad++; $display("FAIL mult_const got=%h_%h want=ffffffff_ffffffeb", hi, lo);
        end
        test_muldiv("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, L);
        total++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            bad++; $display("FAIL multu_const got=%h_%h want=fffffffe_00000001", hi, lo);
        end
        for (int i = 0; i < 4; i++) begin
            test_muldiv("mul_rand", 3'(i & 1), $urandom, $urandom, L);
        end
    endtask

    task automatic test_div();
        test_div_case: begin end
        test_muldiv("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, W + 1);
        total++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL div_const got=%h_%h want=ffffffff_fffffffd", hi, lo);
        end
        test_muldiv("divu", 3'd3, 32'hFFFF_FFF9, 32'd2, W + 1);
        total++; if (lo !== 32'h7FFF_FFFC || hi !== 32'h0000_0001) begin
            bad++; $display("FAIL divu_const got=%h_%h want=00000001_7ffffffc", hi, lo);
        end
        test_muldiv("div_pos_neg", 3'd2, 32'd100, 32'hFFFF_FFF9, W + 1);
        for (int i = 0; i < 4; i++) begin
            test_muldiv("div_rand", 3'(2 + (i & 1)), $urandom, 32'($urandom_range(1, 70000)) ^ (i[0] ? 32'h0 : 32'h8000_0000), W + 1);
        end
    endtask

    task automatic test_div_special();
        test_muldiv("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, W + 1);
        total++; if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
            bad++; $display("FAIL div_ovf_const got=%h_%h want=00000000_80000000", hi, lo);
        end
        test_muldiv("div_zero",  3'd2, 32'd5, 32'd0, W + 1);
        total++; if (lo !== 32'hFFFF_FFFF || hi !== 32'd5) begin
            bad++; $display("FAIL div_zero_const got=%h_%h want=00000005_ffffffff", hi, lo);
        end
        test_muldiv("divu_zero", 3'd3, 32'hF000_0001, 32'd0, W + 1);
    endtask

    // Starts issued while a divide is in flight must be dropped.
    task automatic test_ignore();
        int cyc; logic dn; logic [63:0] exp;
        issue(3'd2, 32'd1000, 32'd7, 1'b1);
        issue(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0);
        issue(3'd0, 32'd9, 32'd9, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ignore_busy got=%b want=1", busy); end
        wait_done(cyc, dn);
        total++; if (cyc + 2 !== W + 1) begin bad++; $display("FAIL ignore_cycles got=%0d want=%0d", cyc + 2, W + 1); end
        total++; if (dn !== 1'b1) begin bad++; $display("FAIL ignore_done got=%b want=1", dn); end
        total++;
        if (sb_q.size() == 0) begin bad++; $display("FAIL ignore_scoreboard empty"); end
        else begin
            exp = sb_q.pop_front();
            if ({hi, lo} !== exp) begin
                bad++; $display("FAIL ignore_result got=%h_%h want=%h_%h", hi, lo, exp[63:32], exp[31:0]);
            end
        end
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_no_mult got=%b want=0", busy); end
    endtask

    task automatic test_async_reset();
        int cyc; logic dn; logic [63:0] exp;
        issue(3'd2, 32'd77, 32'd5, 1'b1);
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL arst_done got=%b want=0", done); end
        total++; if (hi !== 32'd0 || lo !== 32'd0) begin bad++; $display("FAIL arst_hilo got=%h_%h want=0_0", hi, lo); end
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_after got=%b want=0", busy); end
        issue(3'd1, 32'd3, 32'd4, 1'b1);
        wait_done(cyc, dn);
        total++; if (cyc !== L || dn !== 1'b1) begin bad++; $display("FAIL arst_multu cyc=%0d done=%b want=%0d/1", cyc, dn, L); end
        exp = sb_q.pop_front();
        total++; if ({hi, lo} !== exp || lo !== 32'd12) begin
            bad++; $display("FAIL arst_multu_result got=%h_%h want=%h_%h", hi, lo, exp[63:32], exp[31:0]);
        end
    endtask

    task automatic test_back_to_back();
        int cyc; logic dn; logic [63:0] exp1, exp2;
        issue(3'd0, 32'h0001_0003, 32'hFFFF_0002, 1'b1);
        wait_done(cyc, dn);
        total++; if (cyc !== L || dn !== 1'b1) begin bad++; $display("FAIL b2b_first cyc=%0d done=%b want=%0d/1", cyc, dn, L); end
        exp1 = sb_q.pop_front();
        total++; if ({hi, lo} !== exp1) begin
            bad++; $display("FAIL b2b_first_result got=%h_%h want=%h_%h", hi, lo, exp1[63:32], exp1[31:0]);
        end
        // Still in the done cycle: this start must be accepted on the very next edge.
        issue(3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", busy); end
        total++; if ({hi, lo} !== exp1) begin
            bad++; $display("FAIL b2b_hold got=%h_%h want=%h_%h", hi, lo, exp1[63:32], exp1[31:0]);
        end
        wait_done(cyc, dn);
        total++; if (cyc !== L || dn !== 1'b1) begin bad++; $display("FAIL b2b_second cyc=%0d done=%b want=%0d/1", cyc, dn, L); end
        exp2 = sb_q.pop_front();
        total++; if ({hi, lo} !== exp2) begin
            bad++; $display("FAIL b2b_second_result got=%h_%h want=%h_%h", hi, lo, exp2[63:32], exp2[31:0]);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_mt();
        test_mul();
        test_div();
        test_div_special();
        test_ignore();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO result registers for the pipelined MIPS core. Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the ALU in the execute stage. The controller issues an op with `start` and stalls HI/LO consumers while `busy` is high.
- Generalises the fixed 32-bit core: operand width and multiply latency are parameters.

Parameters:
- WIDTH, 32, operand and HI/LO width (even, >= 4).
- MUL_LATENCY, 5, cycles `busy` stays high for MULT/MULTU (>= 1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  issue strobe, sampled on clk rising edge
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved
- src_a  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
- src_b  input  WIDTH  rt operand (divisor / multiplier)
- busy  output  1  operation in flight; new start ignored
- done  output  1  one-cycle pulse when HI/LO updated by a mul/div
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (async, any state):
  - hi = 0, lo = 0, busy = 0, done = 0.
  - FSM goes to IDLE and any in-flight operation is aborted.
- FSM states:
  - IDLE -> MUL on accepted MULT/MULTU.
  - IDLE -> DIV on accepted DIV/DIVU.
  - MUL -> IDLE after MUL_LATENCY cycles.
  - DIV -> FIX after WIDTH iterations.
  - FIX -> IDLE after 1 cycle.
- Acceptance:
  - `start` is accepted only in IDLE with busy = 0.
  - `start` while busy is ignored; operands and op are not captured.
  - Reserved ops are ignored and cause no state change.
- Operand capture: src_a, src_b and the signed flag are registered at the accepting edge. Inputs may change afterwards.
- MTHI/MTLO:
  - hi (resp. lo) <= src_a at the accepting edge.
  - busy stays 0 and done is not pulsed.
- MULT/MULTU, accepting edge k:
  - busy = 1 during cycles k+1 .. k+MUL_LATENCY.
  - At edge k+MUL_LATENCY: {hi, lo} <= full 2*WIDTH product, busy -> 0, done = 1 for that one cycle.
  - MULT uses a signed product; MULTU uses an unsigned product.
  - The internal pipeline or shift structure is free, provided the latency is exact.
- DIV/DIVU:
  - Radix-2 restoring division on magnitudes: WIDTH iteration cycles plus 1 FIX cycle, so busy is high for WIDTH+1 cycles. done pulses on the edge busy falls.
  - lo = quotient, hi = remainder.
  - Signed (DIV): quotient truncated toward zero; remainder takes the sign of the dividend; FIX applies the negations.
  - Signed overflow, MIN / -1: lo = MIN, hi = 0.
  - Divide by zero, both DIV and DIVU: lo = all-ones, hi = src_a. This is detected at capture, still takes the full WIDTH+1 cycles, and still pulses done.
- Register holding:
  - hi/lo hold their previous values for the whole busy period; values read then are stale.
  - hi/lo change only at the completion edge, an MTHI/MTLO edge, or reset.
- Back-to-back: a new start is accepted in the cycle after done (busy = 0), and there is no idle gap requirement.
- busy and done are Moore outputs, registered directly from the FSM.

Test Plan:
(WIDTH=32, MUL_LATENCY=5)
- MULT, src_a=0xFFFFFFFD, src_b=7 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, one-cycle done. Then MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7/2 (0xFFFFFFF9, 2) -> busy 33 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU same operands -> lo=0x7FFFFFFC, hi=0x00000001.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIV 5/0 -> lo=0xFFFFFFFF, hi=5, busy 33 cycles, done pulses.
- MTLO 0x12345678 when idle -> lo updates next edge, busy=0, done=0. During a DIV, issue start with MTHI and then MULT -> both ignored; hi/lo end as the DIV result only.
- rst asserted asynchronously at cycle 10 of a DIV, mid-cycle -> busy, done, hi and lo go to 0 before the next edge. After release, MULTU 3*4 -> lo=12, hi=0 after 5 cycles.
- Back-to-back: start MULT with the data already applied in the cycle done is high -> accepted at that edge, second result after 5 more cycles; the first result stays on hi/lo until then.
